// File: rtl/conv_feeder.sv
// Convolution feeder: shifts accepted samples through a TAPS-deep delay line and
// presents each tap alongside its coefficient as one wide word per shift.
module conv_feeder #(
   parameter int TAPS      = 16,
   parameter int dataWidth = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coefWe,
   input  logic [3:0]           coefAddr,
   input  logic [31:0]          coefData,
   input  logic                 start,
   input  logic [15:0]          lenIn,
   input  logic [31:0]          sIn,
   input  logic                 sValid,
   output logic                 sReady,
   output logic [dataWidth-1:0] dataO,
   output logic                 oValid,
   output logic                 accClr,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                state_q, state_d;
   logic [TAPS-1:0][31:0] tap_q, tap_d;
   logic [TAPS-1:0][31:0] coef_q, coef_d;
   logic [15:0]           len_q, len_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [15:0]           fcnt_q, fcnt_d;
   logic                  ovalid_q, ovalid_d;
   logic                  accclr_q, accclr_d;
   logic                  done_q, done_d;

   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      coef_d   = coef_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      fcnt_d   = fcnt_q;
      ovalid_d = 1'b0;
      accclr_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // Addresses at or above TAPS match no register and are dropped.
            if (coefWe) begin
               for (int k = 0; k < TAPS; k++)
                  if (coefAddr == 4'(k)) coef_d[k] = coefData;
            end
            if (start) begin
               len_d   = lenIn;
               tap_d   = '0;
               cnt_d   = '0;
               fcnt_d  = '0;
               state_d = (lenIn != 16'd0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (sValid) begin
               tap_d[0] = sIn;
               for (int k = 1; k < TAPS; k++) tap_d[k] = tap_q[k-1];
               ovalid_d = 1'b1;
               accclr_d = (cnt_q == 16'd0);
               cnt_d    = cnt_q + 16'd1;
               if (cnt_q == len_q - 16'd1) begin
                  fcnt_d  = '0;
                  state_d = (TAPS > 1) ? FLUSH : DONE;
               end
            end
         end
         FLUSH: begin
            tap_d[0] = 32'h0;
            for (int k = 1; k < TAPS; k++) tap_d[k] = tap_q[k-1];
            ovalid_d = 1'b1;
            fcnt_d   = fcnt_q + 16'd1;
            if (fcnt_q == 16'(TAPS - 2)) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tap_q    <= '0;
         coef_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         fcnt_q   <= '0;
         ovalid_q <= 1'b0;
         accclr_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tap_q    <= tap_d;
         coef_q   <= coef_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         ovalid_q <= ovalid_d;
         accclr_q <= accclr_d;
         done_q   <= done_d;
      end
   end

   assign sReady = (state_q == RUN);
   assign busy   = (state_q != IDLE);
   assign oValid = ovalid_q;
   assign accClr = accclr_q;
   assign done   = done_q;

   for (genvar k = 0; k < TAPS; k++) begin : g_pack
      assign dataO[64*k +: 32]    = tap_q[k];
      assign dataO[64*k+32 +: 32] = coef_q[k];
   end

endmodule
